// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive datapath.
//   rx_state_e  - receiver FSM states
//   OVERSAMPLE  - baud_tick pulses per bit period
//   MID_SAMPLE  - START-state tick count at which the start bit is re-checked
//   BIT_END     - tick count at which a data/parity/stop bit is sampled
package uart_pkg;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] BIT_END    = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/rx_sipo.sv
// rx_sipo: serial-in / parallel-out shift register, LSB first.
// Each enabled cycle shifts right and loads the serial bit at the MSB, so after
// W shifts the first bit received sits in bit 0.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   i_shift_en in  shift strobe
//   i_sdata    in  serial bit
//   o_pdata    out parallel word [W-1:0]
module rx_sipo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_shift_en,
  input  logic         i_sdata,
  output logic [W-1:0] o_pdata
);

  logic [W-1:0] r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_shift <= '0;
    else if (i_shift_en) r_shift <= {i_sdata, r_shift[W-1:1]};
  end

  assign o_pdata = r_shift;

endmodule

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: UART receiver, serial line -> held byte with valid/ready.
// Frame: start(0), DATA_BITS data LSB first, [even parity], stop(1).
// The line is sampled on a 16x oversample enable.
//
// Optional feature macro: UART_RX_PARITY_EN (adds the even-parity bit and
// parity_err; without it parity_err is tied 0).
//
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous active-low reset
//   baud_tick   in  one-clk enable at 16x baud
//   rx_in       in  raw serial line (async, idle high)
//   rx_ready    in  consumer accepts data_out this cycle
//   data_out    out received word, stable while data_valid
//   data_valid  out data_out holds an unconsumed word
//   frame_err   out one-clk pulse: stop bit sampled 0
//   parity_err  out one-clk pulse: parity mismatch
//   overrun_err out one-clk pulse: new word arrived while old one unconsumed
module uart_rx_datapath #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);
  import uart_pkg::*;

  if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_os
    $error("uart_rx_datapath: OVERSAMPLE must be 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_rx_datapath: DATA_BITS must be 5..8");
  end

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // Two-flop synchronizer; reset to the idle (high) line level.
  logic r_sync1, r_sync2;
  logic w_rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  rx_state_e            r_state;
  logic [3:0]           r_tick_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] w_shift;
  logic                 w_tick_end;
  logic                 w_shift_en;
  logic                 w_stop_smp;
  logic                 w_commit;

  assign w_tick_end = baud_tick && (r_tick_cnt == BIT_END);
  assign w_shift_en = (r_state == DATA) && w_tick_end;
  assign w_stop_smp = (r_state == STOP) && w_tick_end;
  assign w_commit   = w_stop_smp && w_rx_s;

  rx_sipo #(.W(DATA_BITS)) u_sipo (
    .clk        (clk),
    .reset      (reset),
    .i_shift_en (w_shift_en),
    .i_sdata    (w_rx_s),
    .o_pdata    (w_shift)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else if (r_state == WAIT_IDLE) begin
      // Untimed: a held break must return high before we re-arm.
      if (w_rx_s) r_state <= IDLE;
    end else if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        START: begin
          if (r_tick_cnt == MID_SAMPLE) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_state    <= w_rx_s ? IDLE : DATA;  // high at mid-bit = glitch
          end else begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
          end
        end
        DATA: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;       // wraps 15 -> 0
          if (r_tick_cnt == BIT_END) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
        PARITY: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (r_tick_cnt == BIT_END) r_state <= STOP;
        end
        STOP: begin
          r_tick_cnt <= r_tick_cnt + 4'd1;
          if (r_tick_cnt == BIT_END) r_state <= w_rx_s ? IDLE : WAIT_IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output word and handshake. A commit that meets an accept in the same
  // cycle replaces the word and keeps data_valid high.
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_smp && !w_rx_s;
      r_overrun   <= w_commit && r_valid && !rx_ready;
      if (w_commit && (!r_valid || rx_ready)) begin
        r_data  <= w_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;

  // Even parity: data bits plus parity bit must XOR to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_parity_err <= 1'b0;
    else        r_parity_err <= (r_state == PARITY) && w_tick_end &&
                                ((^w_shift) ^ w_rx_s);
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;

endmodule

// File: doc/uart_rx_datapath.md
Name: uart_rx_datapath

Overview:
- UART receiver datapath, the counterpart to the TX datapath: converts the serial line back into bytes.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional even-parity bit, one stop bit (1).
- Samples the line on a 16x-oversample enable (baud_tick) from the existing baud-rate generator.
- Output is a held byte with a valid/ready handshake toward the consumer.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; fixed at 16 in this revision.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- baud_tick  input  1  single-clk enable pulse at 16x baud rate.
- rx_in  input  1  raw serial line, asynchronous to clk, idle high.
- rx_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  DATA_BITS  received data word.
- data_valid  output  1  data_out holds an unconsumed word.
- frame_err  output  1  one-clk pulse: stop bit sampled 0.
- parity_err  output  1  one-clk pulse: parity mismatch; tied 0 without the macro.
- overrun_err  output  1  one-clk pulse: frame completed while data_valid was still high.

Behaviour:
- Reset (async assert, sync deassert in use):
  - sync flops go to 1.
  - FSM goes to IDLE; tick_cnt, bit_idx and shift register clear.
  - data_out=0; data_valid=0; all error outputs 0.
- Synchronizer: 2 flops on rx_in; all FSM decisions use rx_s (2-clk latency).
- tick_cnt (4b) and bit_idx (3b) advance only on cycles with baud_tick=1. When baud_tick=0, all FSM state holds.
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: on each tick, tick_cnt++. At tick_cnt==7 (mid start bit):
  - rx_s=0: go to DATA, tick_cnt=0, bit_idx=0.
  - rx_s=1: glitch; return to IDLE with no output.
- DATA: on each tick, tick_cnt++. At tick_cnt==15, sample rx_s into shift[DATA_BITS-1] and shift right (LSB first), bit_idx++.
  - After bit DATA_BITS-1: go to PARITY if the macro is defined, else STOP. tick_cnt wraps to 0.
- STOP: at tick_cnt==15, sample rx_s.
  - 1: frame good; go to IDLE and commit the word (see below).
  - 0: frame_err=1 for one clk, word discarded, go to WAIT_IDLE.
- WAIT_IDLE: wait for rx_s==1 (a tick is not required), then go to IDLE. This prevents a break condition from retriggering START.
- Commit (clk after the stop-bit sample):
  - data_valid=0: data_out<=shift, data_valid<=1.
  - data_valid=1 and rx_ready=0: overrun_err=1 for one clk; new word dropped; old data_out kept.
  - data_valid=1 and rx_ready=1 in the same cycle: the accept and the new load both happen. data_out gets the new word, data_valid stays 1, no overrun.
- Handshake: data_valid && rx_ready clears data_valid next clk, unless a same-cycle commit applies. data_out is stable while data_valid=1.
- Rules for simultaneous events:
  - Error pulses never coincide with a commit.
  - A parity error and a frame error on the same frame produce both pulses, on their respective sample cycles.
- Latency: data_valid rises 2 clks (sync) plus 1 clk after the baud_tick that samples the mid stop bit.
- Reset mid-frame: aborts immediately and reverts to reset values; no partial word is emitted.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP; at tick_cnt==15, sample rx_s.
  - Even parity: if XOR(shift, rx_s) != 0, parity_err=1 for one clk.
  - The word is still committed if the stop bit is good; software decides what to do with it.
- Undefined: no PARITY state; parity_err is tied to 0; frame length is 1+DATA_BITS+1 bits.

Decomposition:
- Package uart_pkg holds:
  - rx_state_e enum {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}.
  - localparams OVERSAMPLE=16, MID_SAMPLE=7, BIT_END=15.
- One sub-module, rx_sipo: shift register with shift_en, serial in, and parallel out [DATA_BITS-1:0], LSB-first. It mirrors the TX PISO.
- FSM, counters and synchronizer live in the top.

Test Plan:
- Clean frame 0xA5 at 16x ticks, rx_ready=1 -> data_out=0xA5, data_valid high exactly 1 clk, no errors.
- Start glitch: rx_in low for 4 ticks then high -> FSM returns to IDLE, data_valid stays 0.
- Stop bit driven 0 on frame 0x3C -> frame_err pulses once, data_valid stays 0. Line held low 40 ticks then high -> the next frame 0x55 is received correctly.
- Frames 0x11 then 0x22 with rx_ready=0 -> data_out=0x11 held, overrun_err pulses at the second commit. Then rx_ready=1 -> data_valid clears.
- rx_ready asserted on the exact commit cycle of the second frame -> data_out=0x22, data_valid stays 1, no overrun.
- With UART_RX_PARITY_EN, frame 0x07 sent with parity bit 0 (wrong) -> parity_err pulse, data_out=0x07 valid. The same frame with parity bit 1 -> no error.
- reset asserted mid-DATA -> all outputs 0 immediately; the next full frame 0xF0 is received correctly.
